// File: rtl/urng_vector_capture_if.sv
// Bundle of the generator inputs, burst control and capture-stream
// handshake for urng_vector_capture. The capture block takes the
// slave view; whoever drives generators and consumes pairs takes master.
interface urng_vector_capture_if #(
  parameter int LEN_W = 16
);
  logic [31:0]      iTaus1;
  logic [31:0]      iTaus2;
  logic             iStart;
  logic [LEN_W-1:0] iBurstLen;
  logic [63:0]      oData;
  logic             oValid;
  logic             iReady;
  logic             oBusy;
  logic             oDone;
  logic             oOverflow;
  logic [LEN_W-1:0] oCount;

  modport slave (
    input  iTaus1, iTaus2, iStart, iBurstLen, iReady,
    output oData, oValid, oBusy, oDone, oOverflow, oCount
  );

  modport master (
    output iTaus1, iTaus2, iStart, iBurstLen, iReady,
    input  oData, oValid, oBusy, oDone, oOverflow, oCount
  );
endinterface

// File: rtl/urng_vector_capture.sv
// Captures a burst of {iTaus1, iTaus2} pairs from two free-running
// Tausworthe generators into a first-word-fall-through FIFO and streams
// them out over a valid/ready handshake. Pairs offered while the FIFO
// is full (and not being popped) are dropped and flagged as overflow.
module urng_vector_capture #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  urng_vector_capture_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [63:0]      fifo_mem [DEPTH];

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             offer_s;
  logic             push_s;
  logic             drop_s;
  logic [63:0]      wr_data_s;

  // FIFO status and the per-cycle push/pop/drop decision
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s     = !empty_s && bus.iReady;
    offer_s   = (state_q == ST_CAPTURE);
    // A full FIFO still accepts the pair when a slot frees up this cycle
    push_s    = offer_s && (!full_s || pop_s);
    drop_s    = offer_s && !push_s;
    wr_data_s = {bus.iTaus1, bus.iTaus2};
  end

  // Next-state logic for the burst FSM, length counter and burst flags
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // Zero-length requests are ignored entirely
        if (bus.iStart && (bus.iBurstLen != '0)) begin
          state_d = ST_CAPTURE;
          rem_d   = bus.iBurstLen;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (push_s) begin
          count_d = count_q + LEN_ONE;
        end else begin
          count_d = count_q;
        end
        if (drop_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (rem_q == LEN_ONE) begin
          state_d = ST_DRAIN;
          rem_d   = '0;
        end else begin
          state_d = ST_CAPTURE;
          rem_d   = rem_q - LEN_ONE;
        end
      end
      ST_DRAIN: begin
        // Always spend at least one cycle here, even with nothing buffered
        if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State, counters and pointers; reset overrides every other update
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Store the captured pair in the slot addressed by the write pointer
  always_ff @(posedge iClk) begin
    if (!iRst && push_s) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= wr_data_s;
    end
  end

  // Outputs decoded straight from flops; head entry shown while non-empty
  always_comb begin
    bus.oValid    = !empty_s;
    bus.oBusy     = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    bus.oDone     = (state_q == ST_DONE);
    bus.oOverflow = ovf_q;
    bus.oCount    = count_q;
    if (empty_s) begin
      bus.oData = 64'd0;
    end else begin
      bus.oData = fifo_mem[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: doc/urng_vector_capture.md
URNG_VECTOR_CAPTURE -- requirements
Module: urng_vector_capture

Interface
REQ-001 Parameter: DEPTH, 16, number of FIFO entries; power of two, minimum 4.
REQ-002 Parameter: LEN_W, 16, width of the burst-length and count fields.
REQ-003 Port: iClk  in  1  single clock; all logic on the rising edge.
REQ-004 Port: iRst  in  1  synchronous, active-high reset.
REQ-005 Port: iTaus1  in  32  uniform word from Tausworthe generator 1, free-running, new value every cycle.
REQ-006 Port: iTaus2  in  32  uniform word from Tausworthe generator 2, free-running, new value every cycle.
REQ-007 Port: iStart  in  1  single-cycle request to begin a capture burst.
REQ-008 Port: iBurstLen  in  LEN_W  number of generator cycles to sample; value is taken when iStart is accepted.
REQ-009 Port: oData  out  64  captured pair {iTaus1, iTaus2}, with iTaus1 in bits [63:32].
REQ-010 Port: oValid  out  1  oData holds a valid captured pair.
REQ-011 Port: iReady  in  1  consumer accepts oData when oValid and iReady are both high.
REQ-012 Port: oBusy  out  1  high in the CAPTURE and DRAIN states.
REQ-013 Port: oDone  out  1  one-cycle pulse when the burst has been fully drained.
REQ-014 Port: oOverflow  out  1  sticky flag: at least one sample in the current burst was dropped.
REQ-015 Port: oCount  out  LEN_W  number of pairs written into the FIFO in the current burst.

Function
REQ-016 The FSM SHALL have four states: IDLE, CAPTURE, DRAIN and DONE.
REQ-017 In IDLE, iStart=1 with iBurstLen!=0 SHALL latch iBurstLen, clear oCount and oOverflow, and move to CAPTURE on the next cycle.
REQ-018 In IDLE, iStart=1 with iBurstLen=0 SHALL be ignored: no state change and no flag change.
REQ-019 In any state other than IDLE, iStart SHALL be ignored.
REQ-020 CAPTURE SHALL last exactly the latched iBurstLen cycles; in each of these cycles the current {iTaus1, iTaus2} is offered to the FIFO once.
REQ-021 An offered pair SHALL be written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-022 An offered pair SHALL otherwise be dropped and oOverflow set to 1; oOverflow stays set until the next accepted iStart or reset.
REQ-023 oCount SHALL increment by 1 for each written pair and SHALL NOT increment for dropped pairs.
REQ-024 After the final CAPTURE cycle the FSM SHALL enter DRAIN, and leave DRAIN for DONE in the cycle after the FIFO becomes empty.
REQ-025 If the FIFO is empty at the end of CAPTURE, the FSM SHALL still pass through DRAIN for one cycle.
REQ-026 DONE SHALL assert oDone for exactly one cycle and then return to IDLE.
REQ-027 oCount and oOverflow SHALL hold their values in IDLE until the next accepted iStart.
REQ-028 The FIFO SHALL be first-word-fall-through: oValid=1 whenever it is non-empty, with oData showing the oldest entry.
REQ-029 Pop SHALL occur on oValid && iReady.
REQ-030 A pair written in cycle N SHALL appear on oData with oValid=1 no earlier than cycle N+1, and in cycle N+1 if the FIFO was empty.
REQ-031 Pairs SHALL leave the FIFO in write order; no pair is duplicated or reordered.
REQ-032 Read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-033 Full SHALL be defined as the pointers' MSBs differing while the lower bits are equal.
REQ-034 oData SHALL hold its value while oValid=1 and iReady=0.
REQ-035 When oValid=0, oData is don't-care.

Reset
REQ-036 iRst=1 SHALL force the following on the next edge: state IDLE, FIFO empty (pointers 0), oValid=0, oBusy=0, oDone=0, oOverflow=0, oCount=0, oData=0.
REQ-037 Reset SHALL take priority over iStart and over all FIFO activity.
REQ-038 Reset asserted during CAPTURE or DRAIN SHALL discard all buffered pairs, with no oDone pulse.

Verification
REQ-039 Basic burst: iBurstLen=5, iReady=1 held -> 5 pairs out in order matching the iTaus values; oCount=5; oOverflow=0; one oDone pulse.
REQ-040 Overflow: DEPTH=16, iBurstLen=20, iReady=0 during CAPTURE -> oCount=16 and oOverflow=1; after iReady=1, exactly the first 16 pairs drain, then oDone.
REQ-041 Full with simultaneous pop: FIFO full, iReady=1 during CAPTURE -> no drops, oOverflow=0, oCount=iBurstLen.
REQ-042 Zero length and busy start: iStart with iBurstLen=0 -> stays IDLE, flags unchanged; iStart during CAPTURE -> ignored, burst length unchanged.
REQ-043 Mid-burst reset: iRst for 1 cycle during DRAIN with 3 entries buffered -> next cycle oValid=0, oCount=0, no oDone; a new burst then runs correctly.
REQ-044 Pointer wrap: 3 back-to-back bursts of iBurstLen=13 with random iReady -> scoreboard shows no loss or reordering across pointer wrap.
